reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised board-level reset generator for the DE0 top: synchronises and debounces the push-button, accepts a synchronous soft-reset request, and releases NUM_OUT active-high reset outputs one after another at a fixed stagger. It sits between the board reset pin and the design cores, and adds multi-domain sequencing and a reset-cause report. Output bit 0 feeds the earliest core (e.g. `GLOBAL` buffer → clocking/JTAG logic) and the highest index feeds application logic.

## Interface
- NUM_OUT, 4: number of sequenced reset outputs (1..16)
- STAGGER_CYCLES, 16: CLK cycles between successive releases (≥2)
- DEBOUNCE_CYCLES, 1000000: cycles a button level must persist (20 ms @ 50 MHz)
- WDT_CYCLES, 50000000: watchdog timeout in cycles (used only with macro)
- CLK  in  1  system clock (CLOCK_50)
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low
- BTNn  in  1  raw push-button, active-low, asynchronous to CLK
- SOFT_RST  in  1  synchronous one-cycle soft-reset request
- KICK  in  1  watchdog kick; ignored without macro
- DOUT  out  NUM_OUT  active-high resets, released index 0 first
- READY  out  1  high when all DOUT released
- CAUSE  out  2  last reset cause: 0 power-on, 1 button, 2 soft, 3 watchdog

## Operation
- Reset values: DOUT all 1, READY 0, CAUSE 0, state HOLD, sync flops and btn_db = 1, all counters 0.
- BTNn passes through 2 synchronising flops, then the debouncer. The debouncer keeps btn_db (reset 1) and a counter. When the synchronised level ≠ btn_db, the counter increments. When it reaches DEBOUNCE_CYCLES-1, btn_db takes the new level and the counter clears. When the levels are equal, the counter clears.
- Trigger: btn_db == 0 (level, so a held button keeps the design in reset), or SOFT_RST, or watchdog timeout.
- HOLD: DOUT all 1. stagger counter counts only while there is no trigger. Any trigger clears the counter. When the counter reaches STAGGER_CYCLES-1, clear DOUT[0], set idx = 1, go to RELEASE.
- RELEASE: every STAGGER_CYCLES cycles, clear DOUT[idx] and increment idx. The edge that clears DOUT[NUM_OUT-1] also sets READY = 1 and enters RUN. With NUM_OUT = 1, HOLD goes directly to RUN.
- RUN: hold outputs steady. On any trigger, the next edge sets DOUT all 1, READY 0, state HOLD.
- Any trigger during RELEASE aborts it on the next edge: DOUT all 1, HOLD.
- CAUSE is updated on the edge that enters HOLD from RELEASE or RUN. Priority for simultaneous triggers: button > watchdog > soft. It is held until the next trigger.
- Counter widths are $clog2 of the respective parameter. The stagger counter wraps to 0 on each release.

## Timing
- Edge 1 = first rising CLK edge with RSTn high and the button up.
- DOUT[k] falls at edge (k+1)·STAGGER_CYCLES. READY rises at edge NUM_OUT·STAGGER_CYCLES.
- BTNn falling at edge 0, held: the synchronised value is visible at edge 2, btn_db falls at edge 2+DEBOUNCE_CYCLES, and DOUT all 1 at edge 3+DEBOUNCE_CYCLES.
- Button release follows the same debounce, then HOLD runs the full stagger again.
- A BTNn glitch shorter than DEBOUNCE_CYCLES has no effect.
- SOFT_RST high at edge n gives DOUT all 1 at edge n+1.
- RSTn asserted mid-sequence immediately (asynchronously) forces all reset values, including CAUSE = 0.

## Configuration
- RESET_SEQ_WDT_EN defined:
  - A watchdog counter runs only in RUN.
  - KICK or leaving RUN clears it.
  - On reaching WDT_CYCLES-1 it fires a one-cycle trigger with CAUSE 3.
- RESET_SEQ_WDT_EN undefined:
  - No watchdog logic.
  - KICK is ignored.
  - CAUSE never takes value 3.

## Structure
- Package `reset_seq_pkg`:
  - state enum {HOLD, RELEASE, RUN}
  - CAUSE encodings CAUSE_POR / CAUSE_BTN / CAUSE_SOFT / CAUSE_WDT
- Sub-module `btn_debounce`: 2-flop synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES. It is reusable for the SW inputs.
- The top of this block holds the FSM, stagger counter, index, and the optional watchdog.

## Test plan
Bench parameters: NUM_OUT=3, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=8, WDT_CYCLES=32.
- Power-on: RSTn released, no other stimulus → DOUT 111→110 at edge 4, 100 at edge 8, 000 plus READY=1 at edge 12, CAUSE=0.
- Glitch: BTNn low for 5 cycles in RUN → no change on DOUT/READY.
- Button: BTNn low held 20 cycles → DOUT=111 and CAUSE=1 at edge 11 after the fall. After release plus debounce, the 4/8/12 sequence repeats.
- Soft reset mid-RELEASE: SOFT_RST pulse right after DOUT=110 → DOUT=111 next edge, CAUSE=2, full sequence restarts. SOFT_RST together with a debounced press → CAUSE=1.
- Watchdog (macro on):
  - No KICK → DOUT=111 and CAUSE=3 at RUN entry + 32 edges.
  - KICK every 20 cycles → never fires.
  - Macro off → never fires.
- Async reset: RSTn pulsed low mid-RUN with CAUSE=2 → DOUT=111, READY=0, CAUSE=0 without waiting for a CLK edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    // Simultaneous triggers resolve as button > watchdog > soft request.
    function automatic logic [1:0] trigger_cause(input logic btn_pressed, input logic wdt_fire);
        if (btn_pressed)
            return CAUSE_BTN;
        else if (wdt_fire)
            return CAUSE_WDT;
        else
            return CAUSE_SOFT;
    endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Two-flop synchroniser followed by a level debouncer; reusable for any
// asynchronous active-low board input (push-buttons, slide switches).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            // A new level must persist for DEBOUNCE_CYCLES before it is accepted.
            if (sync_2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset generator: debounced button, soft request and optional watchdog
// (enabled by defining RESET_SEQ_WDT_EN) feed a staggered multi-output release.
module reset_sequencer #(
    parameter int NUM_OUT         = 4,
    parameter int STAGGER_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WDT_CYCLES      = 50000000
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               BTNn,
    input  logic               SOFT_RST,
    input  logic               KICK,
    output logic [NUM_OUT-1:0] DOUT,
    output logic               READY,
    output logic [1:0]         CAUSE
);

    import reset_seq_pkg::*;

    localparam int STG_W = $clog2(STAGGER_CYCLES);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [STG_W-1:0] STG_MAX  = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

    state_t           state;
    logic [STG_W-1:0] stg_cnt;
    logic [IDX_W-1:0] idx;
    logic             btn_db;
    logic             wdt_fire;
    logic             trigger;
    logic [1:0]       next_cause;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (CLK),
        .rst_n(RSTn),
        .din  (BTNn),
        .level(btn_db)
    );

    // The debounced button is level-sensitive so a held button keeps everything in reset.
    assign trigger    = ~btn_db | SOFT_RST | wdt_fire;
    assign next_cause = trigger_cause(~btn_db, wdt_fire);

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_fire = (state == RUN) && (wdt_cnt == WDT_MAX);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            wdt_cnt <= '0;
        else if ((state != RUN) || KICK || wdt_fire)
            wdt_cnt <= '0;
        else
            wdt_cnt <= wdt_cnt + 1'b1;
    end
`else
    logic unused_wdt;

    assign wdt_fire   = 1'b0;
    assign unused_wdt = KICK | (WDT_CYCLES < 2);
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= HOLD;
            DOUT    <= '1;
            READY   <= 1'b0;
            CAUSE   <= CAUSE_POR;
            stg_cnt <= '0;
            idx     <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (trigger) begin
                        stg_cnt <= '0;
                    end else if (stg_cnt == STG_MAX) begin
                        stg_cnt <= '0;
                        if (NUM_OUT == 1) begin
                            DOUT  <= '0;
                            READY <= 1'b1;
                            state <= RUN;
                        end else begin
                            DOUT[0] <= 1'b0;
                            idx     <= IDX_W'(1);
                            state   <= RELEASE;
                        end
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (trigger) begin
                        DOUT    <= '1;
                        READY   <= 1'b0;
                        CAUSE   <= next_cause;
                        stg_cnt <= '0;
                        state   <= HOLD;
                    end else if (stg_cnt == STG_MAX) begin
                        stg_cnt   <= '0;
                        DOUT[idx] <= 1'b0;
                        idx       <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            READY <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (trigger) begin
                        DOUT    <= '1;
                        READY   <= 1'b0;
                        CAUSE   <= next_cause;
                        stg_cnt <= '0;
                        state   <= HOLD;
                    end
                end
                default: begin
                    DOUT    <= '1;
                    READY   <= 1'b0;
                    stg_cnt <= '0;
                    state   <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scoreboard bench for reset_sequencer (NUM_OUT=3, STAGGER=4, DEBOUNCE=8, WDT=32);
// expectations follow RESET_SEQ_WDT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NUM_OUT = 3;

`ifdef RESET_SEQ_WDT_EN
    localparam logic [2:0] WDT_DOUT  = 3'b111;
    localparam logic       WDT_READY = 1'b0;
    localparam logic [1:0] WDT_CAUSE = 2'd3;
`else
    localparam logic [2:0] WDT_DOUT  = 3'b000;
    localparam logic       WDT_READY = 1'b1;
    localparam logic [1:0] WDT_CAUSE = 2'd1;
`endif

    logic               CLK = 1'b0;
    logic               RSTn;
    logic               BTNn;
    logic               SOFT_RST;
    logic               KICK;
    logic [NUM_OUT-1:0] DOUT;
    logic               READY;
    logic [1:0]         CAUSE;

    typedef struct {
        string      tag;
        logic [2:0] dout;
        logic       ready;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    reset_sequencer #(
        .NUM_OUT        (NUM_OUT),
        .STAGGER_CYCLES (4),
        .DEBOUNCE_CYCLES(8),
        .WDT_CYCLES     (32)
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .BTNn    (BTNn),
        .SOFT_RST(SOFT_RST),
        .KICK    (KICK),
        .DOUT    (DOUT),
        .READY   (READY),
        .CAUSE   (CAUSE)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [2:0] d, input logic r, input logic [1:0] c);
        exp_t e;
        e.tag   = tag;
        e.dout  = d;
        e.ready = r;
        e.cause = c;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got dout=%b ready=%b cause=%0d, no expectation queued", DOUT, READY, CAUSE);
        end else begin
            e = sb.pop_front();
            assert (DOUT === e.dout && READY === e.ready && CAUSE === e.cause)
            else begin
                errors++;
                $error("FAIL %s got dout=%b ready=%b cause=%0d expected dout=%b ready=%b cause=%0d",
                       e.tag, DOUT, READY, CAUSE, e.dout, e.ready, e.cause);
            end
        end
    endtask

    initial begin
        RSTn     = 1'b0;
        BTNn     = 1'b1;
        SOFT_RST = 1'b0;
        KICK     = 1'b1;

        push_exp("reset", 3'b111, 1'b0, 2'd0);
        cycles(3); chk();

        // Power-on release: edges counted from the first edge with RSTn high.
        RSTn = 1'b1;
        push_exp("por_e3",  3'b111, 1'b0, 2'd0);
        push_exp("por_e4",  3'b110, 1'b0, 2'd0);
        push_exp("por_e7",  3'b110, 1'b0, 2'd0);
        push_exp("por_e8",  3'b100, 1'b0, 2'd0);
        push_exp("por_e11", 3'b100, 1'b0, 2'd0);
        push_exp("por_e12", 3'b000, 1'b1, 2'd0);
        cycles(3); chk();
        cycles(1); chk();
        cycles(3); chk();
        cycles(1); chk();
        cycles(3); chk();
        cycles(1); chk();

        // Short glitch in RUN must be filtered.
        for (int i = 0; i < 20; i++) push_exp("glitch", 3'b000, 1'b1, 2'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 0) BTNn = 1'b0;
            if (i == 5) BTNn = 1'b1;
            cycles(1); chk();
        end

        // Held button press, then release and full re-sequence.
        BTNn = 1'b0;
        push_exp("btn_e10", 3'b000, 1'b1, 2'd0);
        push_exp("btn_e11", 3'b111, 1'b0, 2'd1);
        push_exp("btn_e20", 3'b111, 1'b0, 2'd1);
        cycles(10); chk();
        cycles(1);  chk();
        cycles(9);  chk();
        BTNn = 1'b1;
        push_exp("btnrel_e13", 3'b111, 1'b0, 2'd1);
        push_exp("btnrel_e14", 3'b110, 1'b0, 2'd1);
        push_exp("btnrel_e18", 3'b100, 1'b0, 2'd1);
        push_exp("btnrel_e22", 3'b000, 1'b1, 2'd1);
        cycles(13); chk();
        cycles(1);  chk();
        cycles(4);  chk();
        cycles(4);  chk();

        // Soft reset from RUN, then again mid-RELEASE.
        SOFT_RST = 1'b1;
        push_exp("soft_run",   3'b111, 1'b0, 2'd2);
        push_exp("soft_e5",    3'b110, 1'b0, 2'd2);
        push_exp("soft_abort", 3'b111, 1'b0, 2'd2);
        push_exp("soft_e9",    3'b111, 1'b0, 2'd2);
        push_exp("soft_e10",   3'b110, 1'b0, 2'd2);
        push_exp("soft_e14",   3'b100, 1'b0, 2'd2);
        push_exp("soft_e18",   3'b000, 1'b1, 2'd2);
        cycles(1); chk();
        SOFT_RST = 1'b0;
        cycles(4); chk();
        SOFT_RST = 1'b1;
        cycles(1); chk();
        SOFT_RST = 1'b0;
        cycles(3); chk();
        cycles(1); chk();
        cycles(4); chk();
        cycles(4); chk();

        // Soft request coincident with a debounced press reports the button.
        BTNn = 1'b0;
        push_exp("btnsoft_e10", 3'b000, 1'b1, 2'd2);
        push_exp("btnsoft_e11", 3'b111, 1'b0, 2'd1);
        push_exp("btnsoft_run", 3'b000, 1'b1, 2'd1);
        cycles(10); chk();
        SOFT_RST = 1'b1;
        cycles(1);  chk();
        SOFT_RST = 1'b0;
        BTNn     = 1'b1;
        cycles(22); chk();

        // Watchdog left unkicked in RUN, then kicked every 20 cycles.
        KICK = 1'b0;
        push_exp("wdt_e31", 3'b000, 1'b1, 2'd1);
        push_exp("wdt_e32", WDT_DOUT, WDT_READY, WDT_CAUSE);
        push_exp("wdt_e44", 3'b000, 1'b1, WDT_CAUSE);
        cycles(31); chk();
        cycles(1);  chk();
        cycles(12); chk();
        for (int r = 0; r < 4; r++) push_exp("wdt_kick", 3'b000, 1'b1, WDT_CAUSE);
        for (int r = 0; r < 4; r++) begin
            cycles(19);
            KICK = 1'b1;
            cycles(1);
            KICK = 1'b0;
            chk();
        end
        KICK = 1'b1;

        // Asynchronous reset mid-RUN with a soft cause recorded.
        SOFT_RST = 1'b1;
        push_exp("async_soft",   3'b111, 1'b0, 2'd2);
        push_exp("async_run",    3'b000, 1'b1, 2'd2);
        push_exp("async_assert", 3'b111, 1'b0, 2'd0);
        push_exp("async_held",   3'b111, 1'b0, 2'd0);
        push_exp("async_e4",     3'b110, 1'b0, 2'd0);
        cycles(1);  chk();
        SOFT_RST = 1'b0;
        cycles(12); chk();
        #2;
        RSTn = 1'b0;
        #1;
        chk();
        cycles(2); chk();
        RSTn = 1'b1;
        cycles(4); chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
